// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared pipeline constants and fetch state encoding
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HELD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - {instr, pc_plus4, valid} pipeline register with write-enable and flush
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic        flush,
  input  logic [31:0] next_instr,
  input  logic [31:0] next_pc_plus4,
  input  logic        next_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  // Flush beats the stall hold so a redirect always kills the wrong-path slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr    <= NOP;
      pc_plus4 <= 32'h0;
      valid    <= 1'b0;
    end else if (flush) begin
      instr    <= NOP;
      pc_plus4 <= 32'h0;
      valid    <= 1'b0;
    end else if (we) begin
      instr    <= next_instr;
      pc_plus4 <= next_pc_plus4;
      valid    <= next_valid;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction fetch: PC, imem handshake, stall buffer, IF/ID register
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_en,
  input  logic        if_id_wr,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc_F,
  output logic [31:0] instr_D,
  output logic [31:0] pc_plus4_D,
  output logic        valid_D
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc_nxt;
  logic [31:0]  req_addr, req_nxt;
  logic [31:0]  hold_buf, buf_nxt;

  logic         accept;
  logic         redirect;
  logic [31:0]  target;
  logic [31:0]  pc_plus4;

  logic [31:0]  next_instr;
  logic [31:0]  next_pc_plus4;
  logic         next_valid;

  assign accept   = pc_en & if_id_wr;
  assign redirect = branch_taken | jump;
  assign target   = branch_taken ? branch_target : jump_target;
  assign pc_plus4 = pc_F + PC_INC;
  assign imem_addr = req_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_F     <= RESET_PC;
      req_addr <= RESET_PC;
      hold_buf <= NOP;
    end else begin
      pc_F     <= pc_nxt;
      req_addr <= req_nxt;
      hold_buf <= buf_nxt;
    end
  end

  // req_addr only moves once the outstanding request is complete, so imem_addr
  // stays stable while pc_F follows redirects ahead of it.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_F;
    req_nxt   = req_addr;
    buf_nxt   = hold_buf;
    unique case (state)
      FETCH: begin
        if (imem_ready && redirect) begin
          pc_nxt  = target;
          req_nxt = target;
        end else if (imem_ready && accept) begin
          pc_nxt  = pc_plus4;
          req_nxt = pc_plus4;
        end else if (imem_ready) begin
          buf_nxt   = imem_rdata;
          state_nxt = HELD;
        end else if (redirect) begin
          pc_nxt    = target;
          state_nxt = DROP;
        end
      end
      HELD: begin
        if (redirect) begin
          pc_nxt    = target;
          req_nxt   = target;
          state_nxt = FETCH;
        end else if (accept) begin
          pc_nxt    = pc_plus4;
          req_nxt   = pc_plus4;
          state_nxt = FETCH;
        end
      end
      DROP: begin
        if (redirect) pc_nxt = target;
        if (imem_ready) begin
          req_nxt   = redirect ? target : pc_F;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Anything other than a delivered word loads a bubble when IF/ID is written.
  always_comb begin
    imem_req      = (state != HELD);
    next_instr    = NOP;
    next_pc_plus4 = 32'h0;
    next_valid    = 1'b0;
    if (state == FETCH && imem_ready && accept) begin
      next_instr    = imem_rdata;
      next_pc_plus4 = pc_plus4;
      next_valid    = 1'b1;
    end else if (state == HELD && accept) begin
      next_instr    = hold_buf;
      next_pc_plus4 = pc_plus4;
      next_valid    = 1'b1;
    end
  end

  if_id_reg u_if_id (
    .clk           (clk),
    .rst           (rst),
    .we            (if_id_wr),
    .flush         (redirect),
    .next_instr    (next_instr),
    .next_pc_plus4 (next_pc_plus4),
    .next_valid    (next_valid),
    .instr         (instr_D),
    .pc_plus4      (pc_plus4_D),
    .valid         (valid_D)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with a scripted instruction memory
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_en, if_id_wr;
  logic        branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc_F, instr_D, pc_plus4_D;
  logic        valid_D;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [31:0] pcf;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .pc_en         (pc_en),
    .if_id_wr      (if_id_wr),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .pc_F          (pc_F),
    .instr_D       (instr_D),
    .pc_plus4_D    (pc_plus4_D),
    .valid_D       (valid_D)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (~a) ^ 32'h3C1D_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, want);
    end
  endtask

  // One clock: drive inputs, queue the post-edge expectation, compare after the edge.
  task automatic cyc(input logic rdy, input logic pe, input logic iw,
                     input logic br, input logic [31:0] bt,
                     input logic jp, input logic [31:0] jt,
                     input logic e_req, input logic [31:0] e_addr, input logic [31:0] e_pcf,
                     input logic [31:0] e_instr, input logic [31:0] e_pc4, input logic e_valid);
    exp_t e;
    exp_t o;
    imem_ready    = rdy;
    imem_rdata    = rdy ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    pc_en         = pe;
    if_id_wr      = iw;
    branch_taken  = br;
    branch_target = bt;
    jump          = jp;
    jump_target   = jt;
    e.req = e_req; e.addr = e_addr; e.pcf = e_pcf;
    e.instr = e_instr; e.pc4 = e_pc4; e.valid = e_valid;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    o = exp_q.pop_front();
    check_eq("imem_req",   {31'b0, imem_req}, {31'b0, o.req});
    check_eq("imem_addr",  imem_addr,  o.addr);
    check_eq("pc_F",       pc_F,       o.pcf);
    check_eq("instr_D",    instr_D,    o.instr);
    check_eq("pc_plus4_D", pc_plus4_D, o.pc4);
    check_eq("valid_D",    {31'b0, valid_D}, {31'b0, o.valid});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    pc_en = 1'b0; if_id_wr = 1'b0;
    branch_taken = 1'b0; jump = 1'b0;
    branch_target = '0; jump_target = '0;
    imem_ready = 1'b0; imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst pc_F",   pc_F,       32'h0);
    check_eq("rst addr",   imem_addr,  32'h0);
    check_eq("rst instr",  instr_D,    32'h0);
    check_eq("rst pc4",    pc_plus4_D, 32'h0);
    check_eq("rst valid",  {31'b0, valid_D}, 32'h0);
    rst = 1'b0;
    #1;
    check_eq("post-rst req", {31'b0, imem_req}, 32'h1);

    // zero-wait streaming
    cyc(1,1,1, 0,0, 0,0, 1, 32'h4,  32'h4,  mem_word(32'h0), 32'h4,  1);
    cyc(1,1,1, 0,0, 0,0, 1, 32'h8,  32'h8,  mem_word(32'h4), 32'h8,  1);
    cyc(1,1,1, 0,0, 0,0, 1, 32'hC,  32'hC,  mem_word(32'h8), 32'hC,  1);

    // word returns during stall -> HELD, released without re-access
    cyc(1,0,0, 0,0, 0,0, 0, 32'hC,  32'hC,  mem_word(32'h8), 32'hC,  1);
    cyc(0,0,0, 0,0, 0,0, 0, 32'hC,  32'hC,  mem_word(32'h8), 32'hC,  1);
    cyc(0,0,0, 0,0, 0,0, 0, 32'hC,  32'hC,  mem_word(32'h8), 32'hC,  1);
    cyc(0,1,1, 0,0, 0,0, 1, 32'h10, 32'h10, mem_word(32'hC), 32'h10, 1);

    // branch during a wait: old address held, stale word dropped
    cyc(0,1,1, 1,32'h40, 0,0, 1, 32'h10, 32'h40, 32'h0, 32'h0, 0);
    cyc(0,1,1, 0,0,      0,0, 1, 32'h10, 32'h40, 32'h0, 32'h0, 0);
    cyc(1,1,1, 0,0,      0,0, 1, 32'h40, 32'h40, 32'h0, 32'h0, 0);
    cyc(1,1,1, 0,0,      0,0, 1, 32'h44, 32'h44, mem_word(32'h40), 32'h44, 1);

    // branch and jump together: branch wins, IF/ID flushed
    cyc(1,1,1, 1,32'h80, 1,32'hC0, 1, 32'h80, 32'h80, 32'h0, 32'h0, 0);
    cyc(1,1,1, 0,0,      0,0,      1, 32'h84, 32'h84, mem_word(32'h80), 32'h84, 1);

    // jump to top of address space, PC+4 wraps
    cyc(1,1,1, 0,0, 1,32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h0, 0);
    cyc(1,1,1, 0,0, 0,0,             1, 32'h0, 32'h0, mem_word(32'hFFFF_FFFC), 32'h0, 1);

    // wait cycle inserts a bubble; redirect out of HELD
    cyc(0,1,1, 0,0,       0,0, 1, 32'h0,   32'h0,   32'h0, 32'h0, 0);
    cyc(1,0,0, 0,0,       0,0, 0, 32'h0,   32'h0,   32'h0, 32'h0, 0);
    cyc(0,0,0, 1,32'h100, 0,0, 1, 32'h100, 32'h100, 32'h0, 32'h0, 0);
    cyc(1,1,1, 0,0,       0,0, 1, 32'h104, 32'h104, mem_word(32'h100), 32'h104, 1);

    // reset in the middle of a wait
    imem_ready = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst pc_F",  pc_F,       32'h0);
    check_eq("midrst addr",  imem_addr,  32'h0);
    check_eq("midrst instr", instr_D,    32'h0);
    check_eq("midrst pc4",   pc_plus4_D, 32'h0);
    check_eq("midrst valid", {31'b0, valid_D}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1,1,1, 0,0, 0,0, 1, 32'h4, 32'h4, mem_word(32'h0), 32'h4, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline. Holds the PC, issues requests to instruction memory over a ready-based handshake, and owns the IF/ID pipeline register. It consumes the load-use stall controls (PC enable, IF/ID write enable) and the ID-stage redirect (taken branch / jump). It buffers instructions that return during a stall and discards responses made stale by a redirect.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_en  in  1  PC update enable from hazard unit (0 = stall).
- if_id_wr  in  1  IF/ID write enable from hazard unit (0 = stall).
- branch_taken  in  1  taken branch resolved in ID this cycle.
- branch_target  in  32  branch destination.
- jump  in  1  jump resolved in ID this cycle.
- jump_target  in  32  jump destination.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address; stable while imem_req=1 and imem_ready=0.
- imem_rdata  in  32  instruction word; valid when imem_ready=1.
- imem_ready  in  1  completes the outstanding request this cycle (may be same cycle as request).
- pc_F  out  32  architectural fetch PC.
- instr_D  out  32  IF/ID instruction (32'h0 = NOP bubble).
- pc_plus4_D  out  32  IF/ID PC+4.
- valid_D  out  1  IF/ID holds a real instruction.

## Operation
- accept = pc_en & if_id_wr. redirect = branch_taken | jump. Target = branch_target if branch_taken, else jump_target (branch wins if both).
- Internal req_addr register drives imem_addr; it is decoupled from pc_F so the address stays stable across redirects.
- State FETCH: imem_req=1.
  - ready & redirect: drop the word, pc_F and req_addr <= target, stay FETCH.
  - ready & accept: IF/ID <= {imem_rdata, pc_F+4, 1}; pc_F and req_addr <= pc_F+4.
  - ready & !accept: word into hold buffer, go HELD.
  - !ready & redirect: pc_F <= target, go DROP.
  - !ready & accept: IF/ID <= bubble.
- State HELD: imem_req=0.
  - redirect: discard buffer, pc_F and req_addr <= target, go FETCH.
  - accept: IF/ID <= {buffer, pc_F+4, 1}; pc_F and req_addr <= pc_F+4; go FETCH.
  - Otherwise hold.
- State DROP: imem_req=1 at old req_addr.
  - ready: discard word, req_addr <= pc_F, go FETCH.
  - Further redirect: pc_F <= new target.
- IF/ID priority: reset > redirect flush (instr_D=0, valid_D=0, pc_plus4_D=0) > if_id_wr=0 hold > load.
- Overflow: PC+4 wraps modulo 2^32.

## Timing
- Reset values: pc_F=RESET_PC, req_addr=RESET_PC, state FETCH, instr_D=0, pc_plus4_D=0, valid_D=0. imem_req=1 in the first cycle after reset deasserts.
- Reset mid-request abandons the transaction. Memory must tolerate a dropped request.
- Latency: with zero-wait memory, an instruction reaches IF/ID 1 cycle after its request, and throughput is 1 per cycle.
- Each wait cycle (imem_ready=0) inserts one bubble into ID.
- Flush takes effect on the edge where redirect=1. The target is requested the next cycle, or after the stale response when in DROP.
- Stall release from HELD loads the buffered word on that edge with no memory re-access.

## Structure
- Shared pipeline package holds:
  - fetch state encoding (FETCH, HELD, DROP);
  - NOP constant 32'h0;
  - RESET_PC default;
  - PC increment constant 4.
- One sub-module, if_id_reg: the {instr, pc_plus4, valid} register with write-enable, flush and async reset. It is reused by downstream pipeline registers.

## Test plan
- Zero-wait memory, no stalls, RESET_PC=0 -> imem_addr 0,4,8 on consecutive cycles; instr_D follows one cycle later with pc_plus4_D 4,8,12 and valid_D=1.
- imem_ready=1 while if_id_wr=pc_en=0 for 3 cycles -> HELD, imem_req=0, IF/ID unchanged; on release buffered word loads, then next fetch at pc_F+4.
- 2-cycle wait at 0x10 with branch_taken (target 0x40) in first wait cycle -> imem_addr stays 0x10 until ready, response dropped; next request 0x40; valid_D=0 throughout.
- Branch_taken and jump together (targets 0x80, 0xC0) -> pc_F=0x80, IF/ID flushed.
- pc_F=0xFFFF_FFFC accepted -> pc_plus4_D=0, next fetch address 0.
- rst asserted mid-wait -> all outputs reset immediately; fetch restarts at RESET_PC after deassert.
